// File: rtl/slice_pack.sv
// Purpose : packs NUM_SLICES narrow slices into one OUTPUT_DATA_WIDTH word with a registered output.
// Latency : the word appears on data_out one cycle after its final slice is accepted.
// Backpressure: only the final slice of a word stalls (data_in_ready low) while an undelivered word is held.
//
// Ports:
//   clk, rst              - rising-edge clock, synchronous active-high reset
//   sync                  - drop the partial word and restart at slice 0
//   data_in/_valid/_ready - slice input handshake
//   data_out/_valid/_ready- packed word output handshake
module slice_pack #(
    parameter ARCHITECTURE      = "BEHAVIORAL",
    parameter SLICE_WIDTH       = 8,
    parameter NUM_SLICES        = 4,
    parameter OUTPUT_DATA_WIDTH = 32,
    parameter OFFSET_REL_TO_MSB = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sync,
    input  logic [SLICE_WIDTH-1:0]       data_in,
    input  logic                         data_in_valid,
    output logic                         data_in_ready,
    output logic [OUTPUT_DATA_WIDTH-1:0] data_out,
    output logic                         data_out_valid,
    input  logic                         data_out_ready
);

    localparam int CW = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
    localparam logic [CW-1:0] LAST = CW'(NUM_SLICES - 1);

    // Elaboration-time configuration guards.
    if (OUTPUT_DATA_WIDTH != SLICE_WIDTH * NUM_SLICES) begin : g_width_err
        $error("slice_pack: OUTPUT_DATA_WIDTH must equal SLICE_WIDTH*NUM_SLICES");
    end
    if (NUM_SLICES < 2 || NUM_SLICES > 64) begin : g_slices_err
        $error("slice_pack: NUM_SLICES must be in 2..64");
    end
    if (ARCHITECTURE != "BEHAVIORAL") begin : g_arch_err
        $error("slice_pack: only the BEHAVIORAL architecture is implemented");
    end

    logic [CW-1:0]                cnt;
    logic [CW-1:0]                eff_cnt;
    logic [OUTPUT_DATA_WIDTH-1:0] acc;
    logic [OUTPUT_DATA_WIDTH-1:0] next_word;
    logic                         accept;
    logic                         deliver;
    logic                         complete;

    // Only the final slice can collide with a held word; earlier slices go
    // into the accumulator and never need to wait.
    always_comb begin
        data_in_ready = 1'b1;
        if (rst) begin
            data_in_ready = 1'b0;
        end else if (cnt == LAST && data_out_valid && !data_out_ready) begin
            data_in_ready = 1'b0;
        end
    end

    assign accept  = data_in_valid && data_in_ready;
    assign deliver = data_out_valid && data_out_ready;

    // A sync arriving with a slice makes that slice position 0 of a fresh
    // word, so both the index and the accumulator base restart here.
    always_comb begin
        int lo;
        eff_cnt   = sync ? '0 : cnt;
        next_word = sync ? '0 : acc;
        for (int k = 0; k < NUM_SLICES; k++) begin
            lo = (OFFSET_REL_TO_MSB != 0) ? OUTPUT_DATA_WIDTH - (k + 1) * SLICE_WIDTH
                                          : k * SLICE_WIDTH;
            if (CW'(k) == eff_cnt) begin
                next_word[lo +: SLICE_WIDTH] = data_in;
            end
        end
    end

    assign complete = accept && (eff_cnt == LAST);

    // Slice counter and accumulator.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            acc <= '0;
        end else if (accept) begin
            if (complete) begin
                cnt <= '0;
                acc <= '0;
            end else begin
                cnt <= eff_cnt + CW'(1);
                acc <= next_word;
            end
        end else if (sync) begin
            cnt <= '0;
            acc <= '0;
        end
    end

    // Output register: a completing word always wins, which also covers the
    // deliver-and-reload case without a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out       <= '0;
            data_out_valid <= 1'b0;
        end else if (complete) begin
            data_out       <= next_word;
            data_out_valid <= 1'b1;
        end else if (deliver) begin
            data_out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_slice_pack.sv
module tb_slice_pack;

    localparam int S = 8;
    localparam int N = 4;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         sync;
    logic [S-1:0] data_in;
    logic         data_in_valid;
    logic         data_out_ready;

    logic         rdy_m, rdy_l;
    logic [W-1:0] out_m, out_l;
    logic         dov_m, dov_l;

    int checks = 0;
    int errors = 0;

    // Reference model state: slices gathered for the word in progress,
    // and the word currently offered downstream.
    logic [S-1:0] part[$];
    logic         pend;
    logic [W-1:0] exp_m, exp_l;
    logic         rdy_low_seen;
    logic         last_rdy;

    always #5 clk = ~clk;

    slice_pack #(.SLICE_WIDTH(S), .NUM_SLICES(N), .OUTPUT_DATA_WIDTH(W),
                 .OFFSET_REL_TO_MSB(1)) u_msb (
        .clk(clk), .rst(rst), .sync(sync),
        .data_in(data_in), .data_in_valid(data_in_valid), .data_in_ready(rdy_m),
        .data_out(out_m), .data_out_valid(dov_m), .data_out_ready(data_out_ready)
    );

    slice_pack #(.SLICE_WIDTH(S), .NUM_SLICES(N), .OUTPUT_DATA_WIDTH(W),
                 .OFFSET_REL_TO_MSB(0)) u_lsb (
        .clk(clk), .rst(rst), .sync(sync),
        .data_in(data_in), .data_in_valid(data_in_valid), .data_in_ready(rdy_l),
        .data_out(out_l), .data_out_valid(dov_l), .data_out_ready(data_out_ready)
    );

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs after the falling edge, check the DUT against
    // the model, advance the model by what the rising edge should do, and
    // return just after that rising edge.
    task automatic cycle(input logic r, input logic s, input logic v,
                         input logic [S-1:0] d, input logic dr);
        logic       exp_rdy;
        logic       acc;
        logic       del;
        logic [W-1:0] wm, wl;
        @(negedge clk);
        rst = r; sync = s; data_in_valid = v; data_in = d; data_out_ready = dr;
        #1;
        exp_rdy = !r && !(part.size() == N - 1 && pend && !dr);
        check("rdy_msb", W'(rdy_m), W'(exp_rdy));
        check("rdy_lsb", W'(rdy_l), W'(exp_rdy));
        check("dov_msb", W'(dov_m), W'(pend));
        check("dov_lsb", W'(dov_l), W'(pend));
        check("out_msb", out_m, exp_m);
        check("out_lsb", out_l, exp_l);
        last_rdy = rdy_m;
        if (v && !rdy_m) rdy_low_seen = 1'b1;

        if (r) begin
            part.delete();
            pend  = 1'b0;
            exp_m = '0;
            exp_l = '0;
        end else begin
            acc = v && exp_rdy;
            del = pend && dr;
            if (s) part.delete();
            if (acc) part.push_back(d);
            if (part.size() == N) begin
                wm = '0;
                wl = '0;
                foreach (part[i]) begin
                    wm = (wm << S) | W'(part[i]);
                    wl = wl | (W'(part[i]) << (S * i));
                end
                exp_m = wm;
                exp_l = wl;
                pend  = 1'b1;
                part.delete();
            end else if (del) begin
                pend = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; sync = 1'b0; data_in = '0; data_in_valid = 1'b0; data_out_ready = 1'b0;
        pend = 1'b0; exp_m = '0; exp_l = '0; rdy_low_seen = 1'b0; last_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state; slices offered during reset are dropped.
        cycle(1, 0, 1, 8'hEE, 1);
        cycle(1, 1, 1, 8'hEF, 0);
        check("reset_dov", W'(dov_m), '0);
        check("reset_out", out_m, '0);

        // 0x11..0x44 with downstream ready.
        cycle(0, 0, 1, 8'h11, 1);
        cycle(0, 0, 1, 8'h22, 1);
        cycle(0, 0, 1, 8'h33, 1);
        cycle(0, 0, 1, 8'h44, 1);
        check("word_msb", out_m, 32'h11223344);
        check("word_lsb", out_l, 32'h44332211);
        check("word_vld", W'(dov_m), 1);
        cycle(0, 0, 0, 8'h00, 1);
        check("one_cycle_vld", W'(dov_m), 0);
        check("retain_out", out_m, 32'h11223344);

        // Backpressure: only the final slice of the second word stalls.
        for (int i = 1; i <= 7; i++) cycle(0, 0, 1, S'(i), 0);
        check("held_word", out_m, 32'h01020304);
        cycle(0, 0, 1, 8'h08, 0);
        check("stall_rdy", W'(last_rdy), 0);
        check("still_held", out_m, 32'h01020304);
        cycle(0, 0, 1, 8'h08, 1);
        check("no_bubble_vld", W'(dov_m), 1);
        check("no_bubble_out", out_m, 32'h05060708);
        cycle(0, 0, 0, 8'h00, 1);
        check("drained", W'(dov_m), 0);

        // sync discards 0xAA/0xBB.
        cycle(0, 0, 1, 8'hAA, 1);
        cycle(0, 0, 1, 8'hBB, 1);
        cycle(0, 1, 1, 8'h01, 1);
        cycle(0, 0, 1, 8'h02, 1);
        cycle(0, 0, 1, 8'h03, 1);
        check("sync_partial", W'(dov_m), 0);
        cycle(0, 0, 1, 8'h04, 1);
        check("sync_word", out_m, 32'h01020304);

        // Twelve back-to-back slices, three words four cycles apart.
        rdy_low_seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cycle(0, 0, 1, S'(i), 1);
            if (i == 3)  check("b2b_w0", out_m, 32'h00010203);
            if (i == 7)  check("b2b_w1", out_m, 32'h04050607);
            if (i == 11) check("b2b_w2", out_m, 32'h08090A0B);
        end
        check("b2b_rdy", W'(rdy_low_seen), 0);
        cycle(0, 0, 0, 8'h00, 1);

        // Reset mid-word, then a clean word.
        cycle(0, 0, 1, 8'hC1, 1);
        cycle(0, 0, 1, 8'hC2, 1);
        cycle(0, 0, 1, 8'hC3, 1);
        cycle(1, 0, 1, 8'hC4, 0);
        check("rst_mid_dov", W'(dov_m), 0);
        check("rst_mid_out", out_m, '0);
        cycle(0, 0, 1, 8'hD1, 1);
        cycle(0, 0, 1, 8'hD2, 1);
        cycle(0, 0, 1, 8'hD3, 1);
        cycle(0, 0, 1, 8'hD4, 1);
        check("post_rst_word", out_m, 32'hD1D2D3D4);

        // Randomized traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            cycle($urandom_range(0, 79) == 0,
                  $urandom_range(0, 11) == 0,
                  $urandom_range(0, 9) < 7,
                  S'($urandom),
                  $urandom_range(0, 9) < 6);
        end
        cycle(0, 0, 0, 8'h00, 1);
        cycle(0, 0, 0, 8'h00, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
